// File: rtl/aia_gateway_pkg.sv
// APLIC gateway shared types: source-mode codes
// and small decode helpers.
package aia_gateway_pkg;

  localparam int SM_W = 3;

  typedef enum logic [2:0] {
    SM_INACTIVE = 3'd0,
    SM_DETACHED = 3'd1,
    SM_RSVD2    = 3'd2,
    SM_RSVD3    = 3'd3,
    SM_EDGE1    = 3'd4,
    SM_EDGE0    = 3'd5,
    SM_LEVEL1   = 3'd6,
    SM_LEVEL0   = 3'd7
  } sm_t;

  function automatic logic is_edge(sm_t m);
    return (m == SM_EDGE1) || (m == SM_EDGE0);
  endfunction

  function automatic logic is_active_low(sm_t m);
    return (m == SM_EDGE0) || (m == SM_LEVEL0);
  endfunction

  // Codes 4..7 are the only ones that observe the wire.
  function automatic logic is_live(sm_t m);
    return m[2];
  endfunction

endpackage

// File: rtl/aia_rr_picker.sv
// Combinational round-robin picker: first set
// request at or after ptr_i, wrapping modulo N.
module aia_rr_picker #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  // scan N positions starting at the pointer
  always_comb begin
    int j;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o   = W'(j);
      end
    end
  end

endmodule

// File: rtl/aia_gateway_ctrl.sv
// Per-source APLIC gateway: sync, rectify, detect,
// latch, and serialise set-pending requests.
module aia_gateway_ctrl
  import aia_gateway_pkg::*;
#(
  parameter int NR_SRC      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NR_SRC)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NR_SRC-1:0]      irq_sources_i,
  input  logic [SM_W*NR_SRC-1:0] sm_i,
  input  logic [NR_SRC-1:0]      pending_i,
  output logic [NR_SRC-1:0]      rectified_o,
  output logic                   setip_valid_o,
  output logic [ID_W-1:0]        setip_id_o,
  input  logic                   setip_ready_i
);

  logic [NR_SRC-1:0] s;
  logic [NR_SRC-1:0] prev_q, prev_d;
  logic [NR_SRC-1:0] event_q, event_d;
  logic [NR_SRC-1:0] rect_q, rect_d;
  logic [NR_SRC-1:0] evt, chg, infl, pick_oh;
  logic [SM_W*NR_SRC-1:0] mode_q, mode_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;
  logic              slot_free;

  for (genvar g = 0; g < NR_SRC; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    // shift the raw wire into the chain
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_sources_i[g]};
    end

    // synchroniser flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= sync_d;
    end

    assign s[g] = sync_q[SYNC_STAGES-1];
  end

  // per-source mode change, rectify and event detect
  always_comb begin
    sm_t  m;
    logic lvl;
    m      = SM_INACTIVE;
    lvl    = 1'b0;
    evt    = '0;
    chg    = '0;
    infl   = '0;
    rect_d = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      m       = sm_t'(sm_i[SM_W*i +: SM_W]);
      chg[i]  = sm_i[SM_W*i +: SM_W]
             != mode_q[SM_W*i +: SM_W];
      infl[i] = (valid_q && id_q == ID_W'(i))
             || event_q[i];
      lvl     = s[i] ^ is_active_low(m);
      if (i != 0 && is_live(m)) begin
        rect_d[i] = lvl;
        if (!chg[i]) begin
          if (is_edge(m))
            evt[i] = lvl
                   & ~(prev_q[i] ^ is_active_low(m));
          else
            evt[i] = lvl & ~pending_i[i] & ~infl[i];
        end
      end
    end
  end

  aia_rr_picker #(
    .N (NR_SRC),
    .W (ID_W)
  ) u_pick (
    .req_i   (event_q),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // output slot refill, pointer advance, latch update
  always_comb begin
    slot_free = ~valid_q | setip_ready_i;
    valid_d   = valid_q;
    id_d      = id_q;
    rr_d      = rr_q;
    pick_oh   = '0;
    if (slot_free) begin
      valid_d = pick_found;
      if (pick_found) begin
        id_d              = pick_idx;
        pick_oh[pick_idx] = 1'b1;
        rr_d = (pick_idx == ID_W'(NR_SRC - 1))
             ? ID_W'(1) : pick_idx + ID_W'(1);
      end
    end
    event_d = ((event_q & ~pick_oh) | evt) & ~chg;
    prev_d  = s;
    mode_d  = sm_i;
  end

  // gateway state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= '0;
      event_q <= '0;
      rect_q  <= '0;
      mode_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      prev_q  <= prev_d;
      event_q <= event_d;
      rect_q  <= rect_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign rectified_o   = rect_q;
  assign setip_valid_o = valid_q;
  assign setip_id_o    = id_q;

endmodule

// File: tb/tb_aia_gateway_ctrl.sv
// Bench for aia_gateway_ctrl: vector table, corner
// sequences and random run against a reference model.
module tb_aia_gateway_ctrl;
  import aia_gateway_pkg::*;

  localparam int NR = 32;
  localparam int SS = 2;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst_ni;
  logic [NR-1:0] irq, pend_rf, rect;
  logic [3*NR-1:0] sm;
  logic ready, valid;
  logic [IW-1:0] id;

  always #5 clk = ~clk;

  aia_gateway_ctrl #(
    .NR_SRC(NR), .SYNC_STAGES(SS), .ID_W(IW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .irq_sources_i (irq),
    .sm_i          (sm),
    .pending_i     (pend_rf),
    .rectified_o   (rect),
    .setip_valid_o (valid),
    .setip_id_o    (id),
    .setip_ready_i (ready)
  );

  int total = 0;
  int bad = 0;

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // reference model: delayed input history,
  // set of latched events, one output slot
  logic [NR-1:0] m_q[$];
  logic [NR-1:0] m_prev, m_evt, m_rect;
  int m_mode[NR];
  bit m_valid, m_hs;
  int m_id, m_rr, m_hsid;

  task automatic model_reset();
    m_q.delete();
    repeat (SS) m_q.push_back('0);
    m_prev = '0; m_evt = '0; m_rect = '0;
    foreach (m_mode[i]) m_mode[i] = 0;
    m_valid = 0; m_id = 0; m_rr = 0;
  endtask

  task automatic model_step();
    logic [NR-1:0] sv, ne;
    int pk, mo;
    bit a, p, lo, chgd, inf, e, free;
    sv = m_q[0];
    m_hs = m_valid && ready;
    m_hsid = m_id;
    free = !m_valid || ready;
    pk = -1;
    if (free)
      for (int k = 0; k < NR; k++)
        if (pk < 0 && m_evt[(m_rr + k) % NR])
          pk = (m_rr + k) % NR;
    ne = m_evt;
    if (pk >= 0) ne[pk] = 1'b0;
    for (int i = 0; i < NR; i++) begin
      mo = int'(sm[3*i +: 3]);
      a = sv[i]; p = m_prev[i];
      lo = (mo == 5 || mo == 7);
      chgd = (mo != m_mode[i]);
      inf = (m_valid && m_id == i) || m_evt[i];
      e = 0;
      if (i > 0 && !chgd)
        case (mo)
          4: e = a && !p;
          5: e = !a && p;
          6: e = a && !pend_rf[i] && !inf;
          7: e = !a && !pend_rf[i] && !inf;
          default: e = 0;
        endcase
      if (chgd) ne[i] = 1'b0;
      else if (e) ne[i] = 1'b1;
      m_rect[i] = (i > 0 && mo >= 4) ? (a ^ lo) : 1'b0;
      m_mode[i] = mo;
    end
    m_evt = ne;
    if (free) begin
      m_valid = (pk >= 0);
      if (pk >= 0) begin
        m_id = pk;
        m_rr = (pk == NR - 1) ? 1 : pk + 1;
      end
    end
    m_prev = sv;
    void'(m_q.pop_front());
    m_q.push_back(irq);
  endtask

  bit dhs;
  logic [IW-1:0] did;
  int hsq[$];

  // one clock: called and returns at a falling edge
  task automatic tick();
    dhs = valid && ready;
    did = id;
    model_step();
    @(posedge clk);
    #1;
    check("valid", 32'(valid), 32'(m_valid));
    check("id", 32'(id), 32'(m_id));
    check("rect", rect, m_rect);
    if (m_hs) pend_rf[m_hsid] = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (dhs) hsq.push_back(int'(did));
    end
  endtask

  task automatic setm(int i, int code);
    sm[3*i +: 3] = 3'(code);
  endtask

  task automatic wait_valid(string nm);
    int w;
    w = 0;
    while (!valid && w < 12) begin
      tick();
      w++;
    end
    check(nm, 32'(valid), 32'd1);
  endtask

  typedef struct packed {
    logic [31:0]     mask;
    logic [2:0]      n;
    logic [3:0][7:0] ids;
  } row_t;

  function automatic row_t mk(logic [31:0] m, int n,
                              int a, int b, int c);
    row_t r;
    r.mask = m; r.n = 3'(n);
    r.ids[0] = 8'(a); r.ids[1] = 8'(b);
    r.ids[2] = 8'(c); r.ids[3] = 8'd0;
    return r;
  endfunction

  row_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int code;
    tbl[0] = mk(32'h4000_0204, 3, 2, 9, 30);
    tbl[1] = mk(32'h0000_0200, 1, 9, 0, 0);
    tbl[2] = mk(32'h4000_0204, 3, 30, 2, 9);
    tbl[3] = mk(32'h8000_0002, 2, 31, 1, 0);
    tbl[4] = mk(32'h0000_000E, 3, 2, 3, 1);

    rst_ni = 1'b0; irq = '0; sm = '0;
    pend_rf = '0; ready = 1'b1;
    model_reset();
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_rect", rect, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // round-robin order table
    foreach (tbl[r]) setm(0, 0);
    setm(1, 4); setm(2, 4); setm(3, 4);
    setm(9, 4); setm(30, 4); setm(31, 4);
    run(4);
    for (int r = 0; r < 5; r++) begin
      hsq.delete();
      irq |= tbl[r].mask;
      run(10);
      irq &= ~tbl[r].mask;
      run(6);
      check("tbl_cnt", hsq.size(), 32'(tbl[r].n));
      for (int j = 0; j < int'(tbl[r].n); j++)
        check("tbl_id", (j < hsq.size()) ? hsq[j] : 255,
              32'(tbl[r].ids[j]));
    end

    // EDGE1 latency and single-cycle request
    irq[3] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("lat_valid", 32'(valid), 32'(t == 4));
      if (t == 4) check("lat_id", 32'(id), 32'd3);
    end
    irq[3] = 1'b0;
    hsq.delete(); run(8);
    check("fall_none", hsq.size(), 0);

    // EDGE0 and mode switch while high
    setm(5, 4); run(2);
    irq[5] = 1'b1;
    hsq.delete(); run(8);
    check("e1_rise", hsq.size(), 1);
    setm(5, 5);
    hsq.delete(); run(6);
    check("mode_sw", hsq.size(), 0);
    irq[5] = 1'b0;
    hsq.delete(); run(8);
    check("e0_fall", hsq.size(), 1);
    check("e0_id", (hsq.size() > 0) ? hsq[0] : 255, 5);
    irq[5] = 1'b1;
    hsq.delete(); run(8);
    check("e0_rise", hsq.size(), 0);

    // LEVEL1 suppression through pending
    setm(7, 6); pend_rf[7] = 1'b0; run(2);
    irq[7] = 1'b1;
    hsq.delete(); run(12);
    check("lvl_once", hsq.size(), 1);
    check("lvl_id", (hsq.size() > 0) ? hsq[0] : 255, 7);
    pend_rf[7] = 1'b0;
    hsq.delete(); run(12);
    check("lvl_again", hsq.size(), 1);
    irq[7] = 1'b0; setm(7, 0); run(3);

    // backpressure with a second edge while stalled
    setm(4, 4); run(2);
    ready = 1'b0; irq[4] = 1'b1;
    wait_valid("bp_valid");
    for (int k = 0; k < 8; k++) begin
      if (k == 1) irq[4] = 1'b0;
      if (k == 3) irq[4] = 1'b1;
      tick();
      check("bp_hold_v", 32'(valid), 32'd1);
      check("bp_hold_id", 32'(id), 32'd4);
    end
    ready = 1'b1;
    hsq.delete(); run(10);
    check("bp_cnt", hsq.size(), 2);
    irq[4] = 1'b0; run(4);

    // source 0 never requests
    setm(0, 4);
    hsq.delete();
    for (int k = 0; k < 10; k++) begin
      irq[0] = ~irq[0];
      run(1);
    end
    check("src0", hsq.size(), 0);
    irq[0] = 1'b0; setm(0, 0);

    // inactive, detached and reserved modes
    setm(12, 0); setm(13, 1); setm(14, 2);
    hsq.delete();
    for (int k = 0; k < 10; k++) begin
      irq[14:12] = 3'(k);
      run(1);
      check("inact_rect", 32'(rect[14:12]), 32'd0);
    end
    check("inact_req", hsq.size(), 0);

    // reset in the middle of a stall
    irq = '0; sm = '0; run(3);
    setm(6, 4); setm(8, 4); run(2);
    ready = 1'b0;
    irq[6] = 1'b1; irq[8] = 1'b1;
    wait_valid("rst_pre_v");
    run(2);
    irq[8] = 1'b0;
    run(1);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_v", 32'(valid), 32'd0);
    check("rst_mid_id", 32'(id), 32'd0);
    model_reset();
    pend_rf = '0;
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1; ready = 1'b1;
    hsq.delete(); run(12);
    check("rst_post_cnt", hsq.size(), 1);
    check("rst_post_id",
          (hsq.size() > 0) ? hsq[0] : 255, 6);

    // random run against the model
    for (int i = 1; i < NR; i++)
      setm(i, int'($urandom_range(0, 7)));
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        code = int'($urandom_range(0, 7));
        setm(int'($urandom_range(0, NR - 1)), code);
      end
      irq ^= $urandom & $urandom & $urandom;
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        pend_rf[$urandom_range(0, NR - 1)] = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
